// File: rtl/q_update_if.sv
// rtl/q_update_if.sv - transition/result bundle between the agent and q_update
//
// Purpose: carries one (s, a, s', r) transition into the Q-table updater and
//          the written value back out.
// Signals:
//   i_valid, i_st, i_at, i_next_st, i_reward   transition from the agent
//   o_ready                                     updater can accept this cycle
//   o_done, o_q_new                             write pulse and written value
//   o_at_max                                    argmax of Q(s',*) (QMAX_OUT_EN only)
// Macro: QMAX_OUT_EN adds o_at_max.
interface q_update_if #(
    parameter int STATES_WIDTH  = 4,
    parameter int ACTIONS_WIDTH = 2,
    parameter int Q_WIDTH       = 16
);
    logic                      i_valid;
    logic [STATES_WIDTH-1:0]   i_st;
    logic [ACTIONS_WIDTH-1:0]  i_at;
    logic [STATES_WIDTH-1:0]   i_next_st;
    logic signed [Q_WIDTH-1:0] i_reward;
    logic                      o_ready;
    logic                      o_done;
    logic signed [Q_WIDTH-1:0] o_q_new;
`ifdef QMAX_OUT_EN
    logic [ACTIONS_WIDTH-1:0]  o_at_max;
`endif

    modport master (
        output i_valid, i_st, i_at, i_next_st, i_reward,
        input  o_ready, o_done, o_q_new
`ifdef QMAX_OUT_EN
        , input o_at_max
`endif
    );

    modport slave (
        input  i_valid, i_st, i_at, i_next_st, i_reward,
        output o_ready, o_done, o_q_new
`ifdef QMAX_OUT_EN
        , output o_at_max
`endif
    );
endinterface

// File: rtl/q_update.sv
// rtl/q_update.sv - Q-table owner applying one temporal-difference update per transition
//
// Purpose: clears the Q-table after reset, then for each accepted transition
//          scans Q(s',*) for its max, reads Q(s,a) and writes
//          Q(s,a) += alpha*(r + gamma*maxQ(s',*) - Q(s,a)), saturated.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     q_update_if.slave: transition in, o_ready / o_done / o_q_new out
// Macro: QMAX_OUT_EN exposes the scan argmax on bus.o_at_max.
module q_update #(
    parameter int STATES_WIDTH  = 4,
    parameter int ACTIONS_WIDTH = 2,
    parameter int Q_WIDTH       = 16,
    parameter int FRAC_BITS     = 8,
    parameter int ALPHA_SHIFT   = 1,
    parameter int GAMMA_SHIFT   = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    q_update_if.slave bus
);
    localparam int IDX_W       = STATES_WIDTH + ACTIONS_WIDTH;
    localparam int NUM_ENTRIES = 2 ** IDX_W;
    localparam int EXT_W       = Q_WIDTH + 2;
    localparam logic signed [EXT_W-1:0] Q_MAX_X = {3'b000, {(Q_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] Q_MIN_X = {3'b111, {(Q_WIDTH-1){1'b0}}};

    // The arithmetic does not depend on the binary point; only its sanity is checked.
    if (FRAC_BITS >= Q_WIDTH) begin : g_frac_check
        $error("FRAC_BITS must be smaller than Q_WIDTH");
    end

    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_SCAN, S_CALC, S_WRITE} state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           clr_idx_q, clr_idx_d;
    logic [ACTIONS_WIDTH-1:0]   k_q, k_d;
    logic [STATES_WIDTH-1:0]    st_q, st_d, nst_q, nst_d;
    logic [ACTIONS_WIDTH-1:0]   at_q, at_d;
    logic signed [Q_WIDTH-1:0]  rew_q, rew_d;
    logic signed [Q_WIDTH-1:0]  max_q, max_d;
    logic [ACTIONS_WIDTH-1:0]   argmax_q, argmax_d;
    logic signed [Q_WIDTH-1:0]  qsa_q, qsa_d;
    logic signed [Q_WIDTH-1:0]  qnew_q, qnew_d;
    logic signed [Q_WIDTH-1:0]  q_out_q, q_out_d;
    logic                       done_q, done_d;
`ifdef QMAX_OUT_EN
    logic [ACTIONS_WIDTH-1:0]   at_max_q, at_max_d;
`endif

    // Q-table: synchronous write, combinational read, cleared by the CLEAR sweep.
    logic signed [Q_WIDTH-1:0]  table_mem [NUM_ENTRIES];
    logic                       tbl_we;
    logic [IDX_W-1:0]           tbl_waddr;
    logic signed [Q_WIDTH-1:0]  tbl_wdata;
    logic signed [Q_WIDTH-1:0]  scan_val;
    logic signed [Q_WIDTH-1:0]  qsa_rd;

    always_ff @(posedge clk) begin
        if (tbl_we) begin
            table_mem[tbl_waddr] <= tbl_wdata;
        end
    end

    assign scan_val = table_mem[{nst_q, k_q}];
    assign qsa_rd   = table_mem[{st_q, at_q}];

    // Update arithmetic, widened by two bits so the intermediate sums cannot wrap.
    logic signed [EXT_W-1:0] max_x, q_x, r_x, gm_x, td_x, sum_x;
    logic signed [Q_WIDTH-1:0] q_sat;

    always_comb begin
        max_x = {{2{max_q[Q_WIDTH-1]}}, max_q};
        q_x   = {{2{qsa_q[Q_WIDTH-1]}}, qsa_q};
        r_x   = {{2{rew_q[Q_WIDTH-1]}}, rew_q};
        gm_x  = max_x - (max_x >>> GAMMA_SHIFT);
        td_x  = r_x + gm_x - q_x;
        sum_x = q_x + (td_x >>> ALPHA_SHIFT);
        if (sum_x > Q_MAX_X) begin
            q_sat = Q_MAX_X[Q_WIDTH-1:0];
        end else if (sum_x < Q_MIN_X) begin
            q_sat = Q_MIN_X[Q_WIDTH-1:0];
        end else begin
            q_sat = sum_x[Q_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        k_d       = k_q;
        st_d      = st_q;
        at_d      = at_q;
        nst_d     = nst_q;
        rew_d     = rew_q;
        max_d     = max_q;
        argmax_d  = argmax_q;
        qsa_d     = qsa_q;
        qnew_d    = qnew_q;
        q_out_d   = q_out_q;
        done_d    = 1'b0;
`ifdef QMAX_OUT_EN
        at_max_d  = at_max_q;
`endif
        tbl_we    = 1'b0;
        tbl_waddr = clr_idx_q;
        tbl_wdata = '0;

        case (state_q)
            S_CLEAR: begin
                tbl_we    = 1'b1;
                tbl_waddr = clr_idx_q;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == {IDX_W{1'b1}}) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (bus.i_valid) begin
                    st_d    = bus.i_st;
                    at_d    = bus.i_at;
                    nst_d   = bus.i_next_st;
                    rew_d   = bus.i_reward;
                    k_d     = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                // k=0 seeds the max; strict > keeps the lowest index on ties.
                if (k_q == '0 || scan_val > max_q) begin
                    max_d    = scan_val;
                    argmax_d = k_q;
                end
                if (k_q == '0) begin
                    qsa_d = qsa_rd;
                end
                k_d = k_q + 1'b1;
                if (k_q == {ACTIONS_WIDTH{1'b1}}) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                qnew_d  = q_sat;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                // The pulse and value become visible together with the table write.
                tbl_we    = 1'b1;
                tbl_waddr = {st_q, at_q};
                tbl_wdata = qnew_q;
                q_out_d   = qnew_q;
                done_d    = 1'b1;
`ifdef QMAX_OUT_EN
                at_max_d  = argmax_q;
`endif
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
            k_q       <= '0;
            st_q      <= '0;
            at_q      <= '0;
            nst_q     <= '0;
            rew_q     <= '0;
            max_q     <= '0;
            argmax_q  <= '0;
            qsa_q     <= '0;
            qnew_q    <= '0;
            q_out_q   <= '0;
            done_q    <= 1'b0;
`ifdef QMAX_OUT_EN
            at_max_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            k_q       <= k_d;
            st_q      <= st_d;
            at_q      <= at_d;
            nst_q     <= nst_d;
            rew_q     <= rew_d;
            max_q     <= max_d;
            argmax_q  <= argmax_d;
            qsa_q     <= qsa_d;
            qnew_q    <= qnew_d;
            q_out_q   <= q_out_d;
            done_q    <= done_d;
`ifdef QMAX_OUT_EN
            at_max_q  <= at_max_d;
`endif
        end
    end

    assign bus.o_ready = (state_q == S_IDLE);
    assign bus.o_done  = done_q;
    assign bus.o_q_new = q_out_q;
`ifdef QMAX_OUT_EN
    assign bus.o_at_max = at_max_q;
`endif

endmodule

// File: tb/tb_q_update.sv
// tb/tb_q_update.sv - scoreboard bench for q_update against an arithmetic Q-learning model
module tb_q_update;
    localparam int SW = 4;
    localparam int AW = 2;
    localparam int QW = 16;
    localparam int AS = 1;
    localparam int GS = 3;
    localparam int NA = 2 ** AW;
    localparam int NE = 2 ** (SW + AW);
    localparam int LATENCY = NA + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    q_update_if #(.STATES_WIDTH(SW), .ACTIONS_WIDTH(AW), .Q_WIDTH(QW)) bus ();

    q_update #(
        .STATES_WIDTH(SW), .ACTIONS_WIDTH(AW), .Q_WIDTH(QW),
        .FRAC_BITS(8), .ALPHA_SHIFT(AS), .GAMMA_SHIFT(GS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int qm [NE];

    typedef struct {
        int qnew;
        int amax;
        int acc;
    } exp_t;
    exp_t exp_q [$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int fdiv(input int x, input int n);
        int r;
        r = x / n;
        if ((x % n != 0) && (x < 0)) r = r - 1;
        return r;
    endfunction

    task automatic model_step(input int s, input int a, input int ns, input int r,
                              output int qn, output int am);
        int mx, gm, td, q;
        mx = qm[ns * NA];
        am = 0;
        for (int k = 1; k < NA; k++) begin
            if (qm[ns * NA + k] > mx) begin
                mx = qm[ns * NA + k];
                am = k;
            end
        end
        q  = qm[s * NA + a];
        gm = mx - fdiv(mx, 2 ** GS);
        td = r + gm - q;
        qn = q + fdiv(td, 2 ** AS);
        if (qn > 32767) qn = 32767;
        if (qn < -32768) qn = -32768;
        qm[s * NA + a] = qn;
    endtask

    task automatic send(input int s, input int a, input int ns, input int r);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (bus.o_ready !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (bus.o_ready !== 1'b1) begin
            check("ready_timeout", int'(bus.o_ready), 1);
            return;
        end
        bus.i_valid   = 1'b1;
        bus.i_st      = SW'(s);
        bus.i_at      = AW'(a);
        bus.i_next_st = SW'(ns);
        bus.i_reward  = QW'(r);
        model_step(s, a, ns, r, e.qnew, e.amax);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        int n;
        n = 0;
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NE; i++) qm[i] = 0;
        #1;
        check("rst_ready", int'(bus.o_ready), 0);
        check("rst_done", int'(bus.o_done), 0);
        check("rst_q_new", int'($signed(bus.o_q_new)), 0);
`ifdef QMAX_OUT_EN
        check("rst_at_max", int'(bus.o_at_max), 0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        while (bus.o_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("clear_cycles", n, NE);
    endtask

    // Monitor: every o_done must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", int'(bus.o_done), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("q_new", int'($signed(bus.o_q_new)), e.qnew);
                    check("latency", cyc - e.acc, LATENCY);
`ifdef QMAX_OUT_EN
                    check("at_max", int'(bus.o_at_max), e.amax);
`endif
                end
            end
        end
    end

    initial begin
        int s, a, ns, r;
        bus.i_valid   = 1'b0;
        bus.i_st      = '0;
        bus.i_at      = '0;
        bus.i_next_st = '0;
        bus.i_reward  = '0;

        do_reset();
        send(0, 1, 2, 'h0100);
        send(0, 1, 2, 'h0100);
        send(1, 0, 0, 0);
        wait_drain();

        // Saturation on a fresh table.
        do_reset();
        repeat (4) send(3, 2, 4, -32768);
        repeat (6) send(7, 1, 7, -32768);
        repeat (10) send(6, 0, 6, 32767);
        wait_drain();

        // Transition offered while busy is dropped.
        send(9, 3, 10, 1000);
        check("ready_busy", int'(bus.o_ready), 0);
        bus.i_valid   = 1'b1;
        bus.i_st      = SW'(9);
        bus.i_at      = AW'(3);
        bus.i_next_st = SW'(9);
        bus.i_reward  = QW'(28672);
        @(negedge clk);
        bus.i_valid = 1'b0;
        wait_drain();
        send(2, 2, 9, 0);
        wait_drain();

        // Reset in the middle of SCAN aborts the update.
        send(0, 1, 2, 'h0100);
        @(negedge clk);
        do_reset();
        send(0, 1, 2, 'h0100);
        send(0, 0, 5, 'h0100);
        wait_drain();

        // Random traffic with variable gaps.
        for (int i = 0; i < 150; i++) begin
            s  = int'($urandom_range(0, 15));
            a  = int'($urandom_range(0, 3));
            ns = ($urandom_range(0, 3) == 0) ? s : int'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: r = 32767;
                1: r = -32768;
                default: r = int'($signed(16'($urandom)));
            endcase
            send(s, a, ns, r);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
